// File: rtl/bpred_btb_if.sv
// Fetch/Decode signal bundle for the bpred_btb branch predictor.
// The master side drives the pipeline controls; the slave side is the predictor.
interface bpred_btb_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pcF;
    logic [ADDR_W-1:0] nextpcF;
    logic              predtakenF;
    logic              stallD;
    logic              flushD;
    logic [ADDR_W-1:0] pcD;
    logic              cfvalidD;
    logic              condD;
    logic              takenD;
    logic [ADDR_W-1:0] targetD;
    logic              mispredictD;
    logic [ADDR_W-1:0] redirectpcD;
    logic              invalidate;

    modport master (
        output pcF, stallD, flushD, pcD, cfvalidD, condD, takenD, targetD, invalidate,
        input  nextpcF, predtakenF, mispredictD, redirectpcD
    );

    modport slave (
        input  pcF, stallD, flushD, pcD, cfvalidD, condD, takenD, targetD, invalidate,
        output nextpcF, predtakenF, mispredictD, redirectpcD
    );
endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped BTB looked up in Fetch, resolved and trained in Decode.
// Define BPRED_BHT_EN to add 2-bit saturating direction counters per entry.
module bpred_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16
) (
    input  logic          clk,
    input  logic          reset,
    bpred_btb_if.slave    bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic              valid_q  [ENTRIES];
    tag_t              tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
`ifdef BPRED_BHT_EN
    logic [1:0]        ctr_q    [ENTRIES];
`else
    // Direction comes from presence alone, so the conditional flag is not needed.
    logic              unused_cond;
    assign unused_cond = bus.condD;
`endif

    logic              predtaken_d_q;
    logic [ADDR_W-1:0] predtarget_d_q;

    idx_t              idx_f, idx_d;
    tag_t              tag_f, tag_d;
    logic              hit_f, hit_d;
    logic              pred_taken_f;
    logic [ADDR_W-1:0] next_pc_f;
    logic              train;

    assign idx_f = bus.pcF[IDX_W+1:2];
    assign tag_f = bus.pcF[ADDR_W-1:IDX_W+2];
    assign idx_d = bus.pcD[IDX_W+1:2];
    assign tag_d = bus.pcD[ADDR_W-1:IDX_W+2];
    assign hit_d = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
    assign train = bus.cfvalidD && !bus.stallD && !bus.invalidate;

    always_comb begin
        hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
`ifdef BPRED_BHT_EN
        pred_taken_f = hit_f && ctr_q[idx_f][1];
`else
        pred_taken_f = hit_f;
`endif
        next_pc_f = pred_taken_f ? target_q[idx_f] : bus.pcF + ADDR_W'(4);
    end

    assign bus.predtakenF = pred_taken_f;
    assign bus.nextpcF    = next_pc_f;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            predtaken_d_q  <= 1'b0;
            predtarget_d_q <= '0;
        end else if (bus.flushD) begin
            predtaken_d_q  <= 1'b0;
            predtarget_d_q <= '0;
        end else if (!bus.stallD) begin
            predtaken_d_q  <= pred_taken_f;
            predtarget_d_q <= next_pc_f;
        end
    end

    // NOTE: combinational outputs get a default first, so no branch can leave them unassigned and infer a latch.
    always_comb begin
        bus.mispredictD = predtaken_d_q;
        bus.redirectpcD = bus.pcD + ADDR_W'(4);
        if (bus.cfvalidD) begin
            bus.mispredictD = (predtaken_d_q != bus.takenD) ||
                              (bus.takenD && (predtarget_d_q != bus.targetD));
            if (bus.takenD) begin
                bus.redirectpcD = bus.targetD;
            end
        end
    end

    // Valid bits (and counters) carry the reset state; invalidate overrides any training.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
`ifdef BPRED_BHT_EN
                ctr_q[i]   <= 2'b01;
`endif
            end
        end else if (bus.invalidate) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (train) begin
`ifdef BPRED_BHT_EN
            if (hit_d) begin
                if (bus.takenD) begin
                    if (!bus.condD) begin
                        ctr_q[idx_d] <= 2'b11;
                    end else if (ctr_q[idx_d] != 2'b11) begin
                        ctr_q[idx_d] <= ctr_q[idx_d] + 2'b01;
                    end
                end else if (ctr_q[idx_d] != 2'b00) begin
                    ctr_q[idx_d] <= ctr_q[idx_d] - 2'b01;
                end
            end else if (bus.takenD) begin
                valid_q[idx_d] <= 1'b1;
                ctr_q[idx_d]   <= bus.condD ? 2'b10 : 2'b11;
            end
`else
            if (bus.takenD) begin
                valid_q[idx_d] <= 1'b1;
            end else if (hit_d) begin
                valid_q[idx_d] <= 1'b0;
            end
`endif
        end else if (!bus.cfvalidD && predtaken_d_q) begin
            valid_q[idx_d] <= 1'b0;
        end
    end

    // NOTE: tag and target storage is not reset; a cleared valid bit makes its contents unobservable.
    always_ff @(posedge clk) begin
        if (train && bus.takenD) begin
            tag_q[idx_d]    <= tag_d;
            target_q[idx_d] <= bus.targetD;
        end
    end
endmodule
